// File: rtl/ex_cond_stage.sv
// Execute-stage ARM condition check, NZCV flag register and E->M pipeline register.
// Latency 1 cycle E->M; StallE holds all state, FlushE (dominant) loads a bubble.
module ex_cond_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallE,
    input  logic        FlushE,
    input  logic        ValidE,
    input  logic [3:0]  CondE,
    input  logic [1:0]  FlagWE,
    input  logic [3:0]  ALUFlagsE,
    input  logic        RegWE,
    input  logic        MemWE,
    input  logic        PCSE,
    input  logic [31:0] ALUResultE,
    input  logic [31:0] WriteDataE,
    input  logic [3:0]  WA3E,
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic        PCSrcM,
    output logic        ValidM,
    output logic [31:0] ALUOutM,
    output logic [31:0] WriteDataM,
    output logic [3:0]  WA3M,
    output logic        CondExE,
    output logic [3:0]  FlagsQ,
    output logic [15:0] SkipCount
);

    typedef struct packed {
        logic        valid;
        logic        reg_w;
        logic        mem_w;
        logic        pc_src;
        logic [31:0] alu_out;
        logic [31:0] wr_data;
        logic [3:0]  wa3;
    } m_t;

    m_t          m_q, m_d;
    logic [3:0]  flags_q, flags_d;
    logic [15:0] skip_q, skip_d;
    logic        go;
    logic        flag_n, flag_z, flag_c, flag_v;

    assign {flag_n, flag_z, flag_c, flag_v} = flags_q;
    assign go = ValidE & ~StallE & ~FlushE;

    // Condition is judged on the architectural flags only; no ALU-flag bypass.
    always_comb begin
        CondExE = 1'b0;
        case (CondE)
            4'b0000: CondExE = flag_z;
            4'b0001: CondExE = ~flag_z;
            4'b0010: CondExE = flag_c;
            4'b0011: CondExE = ~flag_c;
            4'b0100: CondExE = flag_n;
            4'b0101: CondExE = ~flag_n;
            4'b0110: CondExE = flag_v;
            4'b0111: CondExE = ~flag_v;
            4'b1000: CondExE = flag_c & ~flag_z;
            4'b1001: CondExE = ~flag_c | flag_z;
            4'b1010: CondExE = (flag_n == flag_v);
            4'b1011: CondExE = (flag_n != flag_v);
            4'b1100: CondExE = ~flag_z & (flag_n == flag_v);
            4'b1101: CondExE = flag_z | (flag_n != flag_v);
            4'b1110: CondExE = 1'b1;
            default: CondExE = 1'b0;
        endcase
    end

    always_comb begin
        flags_d = flags_q;
        skip_d  = skip_q;
        if (go) begin
            if (CondExE) begin
                if (FlagWE[1]) flags_d[3:2] = ALUFlagsE[3:2];
                if (FlagWE[0]) flags_d[1:0] = ALUFlagsE[1:0];
            end else if (skip_q != 16'hFFFF) begin
                skip_d = skip_q + 16'd1;
            end
        end
    end

    // An empty Execute slot becomes a fully zeroed bubble, same as a flush.
    always_comb begin
        m_d = m_q;
        if (FlushE) begin
            m_d = '0;
        end else if (!StallE) begin
            if (ValidE) begin
                m_d.valid   = 1'b1;
                m_d.reg_w   = RegWE & CondExE;
                m_d.mem_w   = MemWE & CondExE;
                m_d.pc_src  = PCSE & CondExE;
                m_d.alu_out = ALUResultE;
                m_d.wr_data = WriteDataE;
                m_d.wa3     = WA3E;
            end else begin
                m_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_q     <= '0;
            flags_q <= 4'b0000;
            skip_q  <= 16'd0;
        end else begin
            m_q     <= m_d;
            flags_q <= flags_d;
            skip_q  <= skip_d;
        end
    end

    assign ValidM     = m_q.valid;
    assign RegWriteM  = m_q.reg_w;
    assign MemWriteM  = m_q.mem_w;
    assign PCSrcM     = m_q.pc_src;
    assign ALUOutM    = m_q.alu_out;
    assign WriteDataM = m_q.wr_data;
    assign WA3M       = m_q.wa3;
    assign FlagsQ     = flags_q;
    assign SkipCount  = skip_q;

endmodule

// File: tb/tb_ex_cond_stage.sv
// Scoreboard bench for ex_cond_stage: per-cycle expected M state queued at drive, checked after the edge.
module tb_ex_cond_stage;

    logic        clk = 1'b0;
    logic        reset, StallE, FlushE, ValidE;
    logic [3:0]  CondE;
    logic [1:0]  FlagWE;
    logic [3:0]  ALUFlagsE;
    logic        RegWE, MemWE, PCSE;
    logic [31:0] ALUResultE, WriteDataE;
    logic [3:0]  WA3E;
    logic        RegWriteM, MemWriteM, PCSrcM, ValidM;
    logic [31:0] ALUOutM, WriteDataM;
    logic [3:0]  WA3M;
    logic        CondExE;
    logic [3:0]  FlagsQ;
    logic [15:0] SkipCount;

    always #5 clk = ~clk;

    ex_cond_stage dut (
        .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE), .ValidE(ValidE),
        .CondE(CondE), .FlagWE(FlagWE), .ALUFlagsE(ALUFlagsE), .RegWE(RegWE),
        .MemWE(MemWE), .PCSE(PCSE), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
        .WA3E(WA3E), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .PCSrcM(PCSrcM),
        .ValidM(ValidM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WA3M(WA3M),
        .CondExE(CondExE), .FlagsQ(FlagsQ), .SkipCount(SkipCount)
    );

    typedef struct {
        logic        valid, reg_w, mem_w, pc_src;
        logic [31:0] alu_out, wr_data;
        logic [3:0]  wa3;
    } exp_m_t;

    exp_m_t      sb_q[$];
    exp_m_t      last_m;
    logic [3:0]  mdl_flags;
    logic [15:0] mdl_skip;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ARM-style evaluation: base test on CondE[3:1], inverted by CondE[0].
    function automatic logic mdl_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cc, v, r;
        {n, z, cc, v} = f;
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cc;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cc & ~z;
            3'd5: r = ~(n ^ v);
            3'd6: r = ~z & ~(n ^ v);
            default: r = 1'b1;
        endcase
        return c[0] ? ~r : r;
    endfunction

    task automatic cyc(input logic rst, input logic stall, input logic flush, input logic valid,
                       input logic [3:0] cond, input logic [1:0] fwe, input logic [3:0] alf,
                       input logic rw, input logic mw, input logic pcs, input logic full_chk);
        exp_m_t e, got;
        logic   pass;
        reset = rst; StallE = stall; FlushE = flush; ValidE = valid;
        CondE = cond; FlagWE = fwe; ALUFlagsE = alf;
        RegWE = rw; MemWE = mw; PCSE = pcs;
        ALUResultE = $urandom; WriteDataE = $urandom; WA3E = 4'($urandom);
        #1;
        pass = mdl_cond(cond, mdl_flags);
        if (!rst) check("condex", {31'd0, CondExE}, {31'd0, pass});
        e = '{default: '0};
        if (rst || flush || (!stall && !valid)) begin
            e = '{default: '0};
        end else if (stall) begin
            e = last_m;
        end else begin
            e.valid = 1'b1; e.reg_w = rw & pass; e.mem_w = mw & pass; e.pc_src = pcs & pass;
            e.alu_out = ALUResultE; e.wr_data = WriteDataE; e.wa3 = WA3E;
        end
        if (rst) begin
            mdl_flags = 4'b0000; mdl_skip = 16'd0;
        end else if (valid && !stall && !flush) begin
            if (pass) begin
                if (fwe[1]) mdl_flags[3:2] = alf[3:2];
                if (fwe[0]) mdl_flags[1:0] = alf[1:0];
            end else if (mdl_skip != 16'hFFFF) begin
                mdl_skip = mdl_skip + 16'd1;
            end
        end
        sb_q.push_back(e);
        last_m = e;
        @(posedge clk); #1;
        got = sb_q.pop_front();
        check("flags", {28'd0, FlagsQ}, {28'd0, mdl_flags});
        check("skip", {16'd0, SkipCount}, {16'd0, mdl_skip});
        if (full_chk) begin
            check("validm", {31'd0, ValidM}, {31'd0, got.valid});
            check("regwm", {31'd0, RegWriteM}, {31'd0, got.reg_w});
            check("memwm", {31'd0, MemWriteM}, {31'd0, got.mem_w});
            check("pcsrcm", {31'd0, PCSrcM}, {31'd0, got.pc_src});
            check("aluoutm", ALUOutM, got.alu_out);
            check("wdatam", WriteDataM, got.wr_data);
            check("wa3m", {28'd0, WA3M}, {28'd0, got.wa3});
        end
        @(negedge clk);
    endtask

    initial begin
        mdl_flags = 4'b0000; mdl_skip = 16'd0;
        last_m = '{default: '0};
        reset = 1'b1; StallE = 1'b0; FlushE = 1'b0; ValidE = 1'b1; CondE = 4'hE;
        FlagWE = 2'b11; ALUFlagsE = 4'hF; RegWE = 1'b1; MemWE = 1'b1; PCSE = 1'b1;
        ALUResultE = '0; WriteDataE = '0; WA3E = '0;
        @(negedge clk);

        // reset while a valid flag-setting instruction sits in E
        cyc(1, 0, 0, 1, 4'hE, 2'b11, 4'hF, 1, 1, 1, 1);
        check("rst_flags", {28'd0, FlagsQ}, 32'd0);
        check("rst_validm", {31'd0, ValidM}, 32'd0);
        check("rst_regwm", {31'd0, RegWriteM}, 32'd0);

        // first Go after reset: EQ fails, NE passes
        cyc(0, 0, 0, 1, 4'h0, 2'b00, 4'h0, 1, 0, 0, 1);
        check("eq_after_rst", {31'd0, RegWriteM}, 32'd0);
        cyc(0, 0, 0, 1, 4'h1, 2'b00, 4'h0, 1, 0, 0, 1);
        check("ne_after_rst", {31'd0, RegWriteM}, 32'd1);

        // CMP sets Z, then ADDEQ writes, ADDNE is skipped
        cyc(0, 0, 0, 1, 4'hE, 2'b11, 4'b0100, 0, 0, 0, 1);
        check("cmp_flags", {28'd0, FlagsQ}, 32'h4);
        cyc(0, 0, 0, 1, 4'h0, 2'b00, 4'h0, 1, 0, 0, 1);
        check("addeq_regw", {31'd0, RegWriteM}, 32'd1);
        cyc(0, 0, 0, 1, 4'h1, 2'b00, 4'h0, 1, 1, 1, 1);
        check("addne_regw", {31'd0, RegWriteM}, 32'd0);
        check("addne_skip", {16'd0, SkipCount}, 32'd2);

        // independent half updates
        cyc(0, 0, 0, 1, 4'hE, 2'b11, 4'b1010, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 4'hE, 2'b10, 4'b0101, 0, 0, 0, 1);
        check("partial_nz", {28'd0, FlagsQ}, 32'h6);
        cyc(0, 0, 0, 1, 4'hE, 2'b01, 4'b1001, 0, 0, 0, 1);
        check("partial_cv", {28'd0, FlagsQ}, 32'h5);

        // load a known M value, stall three cycles with flag-setting and failing inputs
        cyc(0, 0, 0, 1, 4'hE, 2'b00, 4'h0, 1, 1, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1, (i == 1) ? 4'hF : 4'hE, 2'b11, 4'hA, 1, 1, 1, 1);
        // flush beats stall, even for a flag-setting instruction
        cyc(0, 1, 1, 1, 4'hE, 2'b11, 4'hF, 1, 1, 1, 1);
        check("flush_bubble", {31'd0, ValidM}, 32'd0);
        cyc(0, 0, 1, 1, 4'hF, 2'b11, 4'h0, 1, 1, 1, 1);
        // empty slot
        cyc(0, 0, 0, 0, 4'hF, 2'b11, 4'h0, 1, 1, 1, 1);

        // random traffic
        for (int i = 0; i < 300; i++)
            cyc(($urandom_range(0, 40) == 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 4) != 0), 4'($urandom), 2'($urandom), 4'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom), 1);

        // full condition table: set flags with AL, probe every code with an empty slot
        for (int f = 0; f < 16; f++) begin
            cyc(0, 0, 0, 1, 4'hE, 2'b11, 4'(f), 0, 0, 0, 1);
            for (int c = 0; c < 16; c++) cyc(0, 0, 0, 0, 4'(c), 2'b11, 4'hF, 1, 1, 1, 0);
        end

        // saturation of the skip counter
        cyc(1, 0, 0, 0, 4'hE, 2'b00, 4'h0, 0, 0, 0, 1);
        for (int i = 0; i < 65534; i++) cyc(0, 0, 0, 1, 4'hF, 2'b00, 4'h0, 0, 0, 0, 0);
        check("skip_fffe", {16'd0, SkipCount}, 32'h0000FFFE);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 4'hF, 2'b00, 4'h0, 1, 0, 0, 1);
        check("skip_sat", {16'd0, SkipCount}, 32'h0000FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
